// File: rtl/multi_key_generator.sv
// rtl/multi_key_generator.sv - round-robin key sweep feeding NUM_CH RC4 decrypt channels
//
// Sweeps keys KEY_LOWER..KEY_UPPER in ascending order. Each key goes to one idle channel,
// chosen round-robin. The sweep stops on the first valid plaintext, or once the key space
// is exhausted and every channel is idle again.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-low
//   start       level; begins a sweep from IDLE, must drop to leave DONE
//   req         per-channel: core idle, wants a key
//   found       per-channel pulse: core's current key decrypted validly
//   grant       one-hot, one cycle: key is valid for that channel
//   key         key being granted (valid while grant != 0)
//   finished    sweep ended (found or exhausted)
//   terminated  sweep ended with no key found
//   found_ch    winning channel index
//   found_key   last key granted to found_ch
//
// Optional feature macro: KEYGEN_STATS_EN adds keys_issued / sweep_cycles counters.

module multi_key_generator #(
    parameter int              KEY_W     = 24,
    parameter logic [KEY_W-1:0] KEY_LOWER = '0,
    parameter logic [KEY_W-1:0] KEY_UPPER = 24'h3FFFFF,
    parameter int              NUM_CH    = 4,
    localparam int             CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [NUM_CH-1:0] req,
    input  logic [NUM_CH-1:0] found,
    output logic [NUM_CH-1:0] grant,
    output logic [KEY_W-1:0]  key,
    output logic              finished,
    output logic              terminated,
    output logic [CH_W-1:0]   found_ch,
    output logic [KEY_W-1:0]  found_key
`ifdef KEYGEN_STATS_EN
    ,
    output logic [KEY_W:0]    keys_issued,
    output logic [31:0]       sweep_cycles
`endif
);

    if (KEY_UPPER < KEY_LOWER) begin : g_bad_key_range
        $error("multi_key_generator: KEY_UPPER must not be below KEY_LOWER");
    end
    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
        $error("multi_key_generator: NUM_CH must be in 1..16");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_CH-1:0]  grant_q, grant_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic               finished_q, finished_d;
    logic               terminated_q, terminated_d;
    logic [CH_W-1:0]    found_ch_q, found_ch_d;
    logic [KEY_W-1:0]   found_key_q, found_key_d;
    logic [KEY_W-1:0]   next_key_q, next_key_d;
    logic [CH_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [KEY_W-1:0]   keyreg_q [NUM_CH];
    logic [KEY_W-1:0]   keyreg_d [NUM_CH];
    logic [NUM_CH-1:0]  valid_q, valid_d;

    // The channel granted last cycle is masked so it has a cycle to drop req.
    logic [NUM_CH-1:0]  eligible;
    logic [NUM_CH-1:0]  found_eff;
    logic               pick_vld;
    logic [CH_W-1:0]    pick_idx;
    logic               hi_vld;
    logic [CH_W-1:0]    hi_idx;
    logic [CH_W-1:0]    lo_idx;
    logic               fnd_vld;
    logic [CH_W-1:0]    fnd_idx;
    logic [KEY_W-1:0]   fnd_key;

    assign eligible  = req & ~grant_q;
    // Channels never granted in this sweep have no key to report.
    assign found_eff = found & valid_q;

    // Round-robin: lowest eligible index at or above rr_ptr, else lowest eligible overall.
    always_comb begin
        hi_vld = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int j = NUM_CH - 1; j >= 0; j--) begin
            if (eligible[j]) begin
                lo_idx = CH_W'(j);
                if (CH_W'(j) >= rr_ptr_q) begin
                    hi_vld = 1'b1;
                    hi_idx = CH_W'(j);
                end
            end
        end
        pick_vld = |eligible;
        pick_idx = hi_vld ? hi_idx : lo_idx;
    end

    // Lowest-index found channel wins. A found cycle never issues a grant, so the
    // key register already holds the last key handed to that channel.
    always_comb begin
        fnd_idx = '0;
        fnd_key = '0;
        for (int j = NUM_CH - 1; j >= 0; j--) begin
            if (found_eff[j]) begin
                fnd_idx = CH_W'(j);
                fnd_key = keyreg_q[j];
            end
        end
        fnd_vld = |found_eff;
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = '0;
        key_d        = key_q;
        finished_d   = finished_q;
        terminated_d = terminated_q;
        found_ch_d   = found_ch_q;
        found_key_d  = found_key_q;
        next_key_d   = next_key_q;
        rr_ptr_d     = rr_ptr_q;
        keyreg_d     = keyreg_q;
        valid_d      = valid_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_RUN;
                    next_key_d   = KEY_LOWER;
                    rr_ptr_d     = '0;
                    finished_d   = 1'b0;
                    terminated_d = 1'b0;
                    valid_d      = '0;
                end
            end
            S_RUN: begin
                if (fnd_vld) begin
                    state_d      = S_DONE;
                    finished_d   = 1'b1;
                    terminated_d = 1'b0;
                    found_ch_d   = fnd_idx;
                    found_key_d  = fnd_key;
                end else if (pick_vld) begin
                    for (int j = 0; j < NUM_CH; j++) begin
                        if (pick_idx == CH_W'(j)) begin
                            grant_d[j]  = 1'b1;
                            valid_d[j]  = 1'b1;
                            keyreg_d[j] = next_key_q;
                        end
                    end
                    key_d      = next_key_q;
                    // May wrap to 0 when KEY_UPPER is all-ones; that value is never issued.
                    next_key_d = next_key_q + KEY_W'(1);
                    rr_ptr_d   = (pick_idx == CH_W'(NUM_CH - 1)) ? '0 : pick_idx + CH_W'(1);
                    if (next_key_q == KEY_UPPER) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (fnd_vld) begin
                    state_d      = S_DONE;
                    finished_d   = 1'b1;
                    terminated_d = 1'b0;
                    found_ch_d   = fnd_idx;
                    found_key_d  = fnd_key;
                end else if (&req) begin
                    state_d      = S_DONE;
                    finished_d   = 1'b1;
                    terminated_d = 1'b1;
                end
            end
            S_DONE: begin
                if (!start) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            key_q        <= '0;
            finished_q   <= 1'b0;
            terminated_q <= 1'b0;
            found_ch_q   <= '0;
            found_key_q  <= '0;
            next_key_q   <= KEY_LOWER;
            rr_ptr_q     <= '0;
            valid_q      <= '0;
            for (int j = 0; j < NUM_CH; j++) begin
                keyreg_q[j] <= '0;
            end
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            key_q        <= key_d;
            finished_q   <= finished_d;
            terminated_q <= terminated_d;
            found_ch_q   <= found_ch_d;
            found_key_q  <= found_key_d;
            next_key_q   <= next_key_d;
            rr_ptr_q     <= rr_ptr_d;
            valid_q      <= valid_d;
            keyreg_q     <= keyreg_d;
        end
    end

    assign grant      = grant_q;
    assign key        = key_q;
    assign finished   = finished_q;
    assign terminated = terminated_q;
    assign found_ch   = found_ch_q;
    assign found_key  = found_key_q;

`ifdef KEYGEN_STATS_EN
    logic [KEY_W:0] keys_issued_q, keys_issued_d;
    logic [31:0]    sweep_cycles_q, sweep_cycles_d;

    always_comb begin
        keys_issued_d  = keys_issued_q;
        sweep_cycles_d = sweep_cycles_q;
        if (state_q == S_IDLE && start) begin
            keys_issued_d  = '0;
            sweep_cycles_d = '0;
        end else begin
            if (grant_d != '0 && keys_issued_q != '1) begin
                keys_issued_d = keys_issued_q + (KEY_W + 1)'(1);
            end
            if ((state_q == S_RUN || state_q == S_DRAIN) && sweep_cycles_q != '1) begin
                sweep_cycles_d = sweep_cycles_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            keys_issued_q  <= '0;
            sweep_cycles_q <= '0;
        end else begin
            keys_issued_q  <= keys_issued_d;
            sweep_cycles_q <= sweep_cycles_d;
        end
    end

    assign keys_issued  = keys_issued_q;
    assign sweep_cycles = sweep_cycles_q;
`endif

endmodule

// File: tb/tb_multi_key_generator.sv
// tb/tb_multi_key_generator.sv - directed self-checking bench for multi_key_generator

module tb_multi_key_generator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: 4 channels, keys 0x00..0x0F
    logic        a_rst_n, a_start;
    logic [3:0]  a_req, a_found, a_grant;
    logic [23:0] a_key, a_fkey;
    logic        a_fin, a_term;
    logic [1:0]  a_fch;

    // Instance B: 2 channels, keys 0x10..0x13
    logic        b_rst_n, b_start;
    logic [1:0]  b_req, b_found, b_grant;
    logic [23:0] b_key, b_fkey;
    logic        b_fin, b_term;
    logic [0:0]  b_fch;

`ifdef KEYGEN_STATS_EN
    logic [24:0] a_ki, b_ki;
    logic [31:0] a_sc, b_sc;
`endif

    multi_key_generator #(
        .KEY_W(24), .KEY_LOWER(24'h000000), .KEY_UPPER(24'h00000F), .NUM_CH(4)
    ) u_dut_a (
        .clk(clk), .reset(a_rst_n), .start(a_start), .req(a_req), .found(a_found),
        .grant(a_grant), .key(a_key), .finished(a_fin), .terminated(a_term),
        .found_ch(a_fch), .found_key(a_fkey)
`ifdef KEYGEN_STATS_EN
        , .keys_issued(a_ki), .sweep_cycles(a_sc)
`endif
    );

    multi_key_generator #(
        .KEY_W(24), .KEY_LOWER(24'h000010), .KEY_UPPER(24'h000013), .NUM_CH(2)
    ) u_dut_b (
        .clk(clk), .reset(b_rst_n), .start(b_start), .req(b_req), .found(b_found),
        .grant(b_grant), .key(b_key), .finished(b_fin), .terminated(b_term),
        .found_ch(b_fch), .found_key(b_fkey)
`ifdef KEYGEN_STATS_EN
        , .keys_issued(b_ki), .sweep_cycles(b_sc)
`endif
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_rst_n = 1'b0; a_start = 1'b0; a_req = 4'h0; a_found = 4'h0;
        b_rst_n = 1'b0; b_start = 1'b0; b_req = 2'b00; b_found = 2'b00;
        tick();
        tick();

        // Reset state
        check("rst_a_grant", a_grant, 0);
        check("rst_a_key",   a_key,   0);
        check("rst_a_fin",   a_fin,   0);
        check("rst_a_term",  a_term,  0);
        check("rst_a_fch",   a_fch,   0);
        check("rst_a_fkey",  a_fkey,  0);
        check("rst_b_grant", b_grant, 0);
        check("rst_b_fin",   b_fin,   0);

        // Full sweep, all channels always requesting: ch0..3 in turn, keys 0..15
        a_rst_n = 1'b1; a_start = 1'b1; a_req = 4'hF;
        tick();
        check("t1_no_grant_on_entry", a_grant, 0);
        for (int i = 0; i < 16; i++) begin
            tick();
            check($sformatf("t1_grant_%0d", i), a_grant, 32'd1 << (i % 4));
            check($sformatf("t1_key_%0d", i),   a_key,   i);
        end
        tick();
        check("t1_fin",   a_fin,   1);
        check("t1_term",  a_term,  1);
        check("t1_grant_done", a_grant, 0);
        a_start = 1'b0;
        tick();

        // found[2] while ch2 holds key 6
        a_start = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("t2_key_%0d", i), a_key, i);
        end
        a_found = 4'b0100;
        tick();
        a_found = 4'b0000;
        check("t2_fin",   a_fin,   1);
        check("t2_term",  a_term,  0);
        check("t2_fch",   a_fch,   2);
        check("t2_fkey",  a_fkey,  6);
        check("t2_grant", a_grant, 0);
        tick();
        tick();
        check("t2_grant_held", a_grant, 0);
        check("t2_fin_held",   a_fin,   1);
        a_start = 1'b0;
        tick();

        // found[1] and found[3] together: ch1 (key 9) wins over ch3 (key 11)
        a_start = 1'b1;
        tick();
        for (int i = 0; i < 12; i++) begin
            tick();
            check($sformatf("t3_key_%0d", i), a_key, i);
        end
        a_found = 4'b1010;
        tick();
        a_found = 4'b0000;
        check("t3_fch",   a_fch,   1);
        check("t3_fkey",  a_fkey,  9);
        check("t3_fin",   a_fin,   1);
        check("t3_term",  a_term,  0);
        check("t3_grant", a_grant, 0);
        a_start = 1'b0;
        tick();

        // found from a channel not yet granted this sweep is ignored; reset mid-RUN
        a_start = 1'b1;
        tick();
        tick();
        check("t5_grant0", a_grant, 4'b0001);
        check("t5_key0",   a_key,   0);
        a_found = 4'b1000;
        tick();
        a_found = 4'b0000;
        check("t5_ignored_grant", a_grant, 4'b0010);
        check("t5_ignored_key",   a_key,   1);
        check("t5_ignored_fin",   a_fin,   0);
        tick();
        tick();
        tick();
        check("t5_key4", a_key, 4);
        a_rst_n = 1'b0;
        tick();
        a_rst_n = 1'b1;
        check("t5_rst_grant", a_grant, 0);
        check("t5_rst_key",   a_key,   0);
        check("t5_rst_fin",   a_fin,   0);
        check("t5_rst_term",  a_term,  0);
        check("t5_rst_fch",   a_fch,   0);
        check("t5_rst_fkey",  a_fkey,  0);
        tick();
        tick();
        check("t5_restart_grant", a_grant, 4'b0001);
        check("t5_restart_key",   a_key,   0);

        // DRAIN waits for all req bits
        for (int i = 1; i < 16; i++) begin
            tick();
            check($sformatf("t6_key_%0d", i), a_key, i);
        end
        a_req = 4'b0111;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("t6_drain_fin_%0d", i),   a_fin,   0);
            check($sformatf("t6_drain_grant_%0d", i), a_grant, 0);
        end
        a_req = 4'hF;
        tick();
        check("t6_fin",  a_fin,  1);
        check("t6_term", a_term, 1);
        a_start = 1'b0;
        tick();
        a_start = 1'b1;
        tick();
        check("t6_fin_cleared", a_fin, 0);
        tick();
        check("t6_regrant", a_grant, 4'b0001);
        check("t6_rekey",   a_key,   0);

        // Two channels, only ch0 requesting: grant/masked alternation, keys from KEY_LOWER
        b_rst_n = 1'b1; b_start = 1'b1; b_req = 2'b01;
        tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i % 2 == 0) begin
                check($sformatf("t4_grant_%0d", i), b_grant, 2'b01);
                check($sformatf("t4_key_%0d", i),   b_key,   32'h10 + i / 2);
            end else begin
                check($sformatf("t4_grant_%0d", i), b_grant, 2'b00);
            end
        end
        tick();
        check("t4_drain_fin", b_fin, 0);
        b_req = 2'b11;
        tick();
        check("t4_fin",  b_fin,  1);
        check("t4_term", b_term, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
